argmax_ranker: RTL and testbench

ARGMAX_RANKER -- requirements
Module: argmax_ranker

---
 rtl/argmax_ranker.sv | 146 ++++++++++++++
 tb/tb_argmax_ranker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_ranker.sv
// argmax_ranker: sequential argmax over a snapshot of N_CLASSES signed scores.
// Reports the winning index and value, the runner-up index, the (never
// wrapping) margin between the two and a low-confidence flag.
//
// Request/result protocol: enable is a level request. Raising it in IDLE
// snapshots in_data and starts a scan. layer_done stays high for as long as
// enable stays high once the scan completes. Dropping enable mid-scan aborts
// the run. Dropping enable in DONE returns to IDLE, so a new run needs
// enable low for at least one edge. busy and layer_done are never high
// together.
module argmax_ranker #(
  parameter int          N_CLASSES = 10,
  parameter int          DATA_W    = 8,
  parameter int unsigned THRESHOLD = 16,
  localparam int         IDX_W     = ($clog2(N_CLASSES) < 1) ? 1 : $clog2(N_CLASSES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] in_data [0:N_CLASSES-1],
  output logic [IDX_W-1:0]         digit,
  output logic signed [DATA_W-1:0] max_value,
  output logic [IDX_W-1:0]         runner_up,
  output logic [DATA_W:0]          margin,
  output logic                     low_conf,
  output logic                     busy,
  output logic                     layer_done,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic signed [DATA_W-1:0] r_snap [0:N_CLASSES-1];
  logic [IDX_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_best_idx;
  logic signed [DATA_W-1:0] r_best_val;
  logic [IDX_W-1:0]         r_sec_idx;
  logic signed [DATA_W-1:0] r_sec_val;
  logic                     r_sec_valid;

  logic signed [DATA_W-1:0] w_elem;
  logic [IDX_W-1:0]         w_best_idx;
  logic signed [DATA_W-1:0] w_best_val;
  logic [IDX_W-1:0]         w_sec_idx;
  logic signed [DATA_W-1:0] w_sec_val;
  logic                     w_last;
  logic [DATA_W:0]          w_margin;
  logic                     w_low_conf;

  // The element under test is the snapshot entry selected by the counter.
  assign w_elem = r_snap[r_cnt];
  assign w_last = (r_cnt == IDX_W'(N_CLASSES - 1));

  // Ranking step: strict > keeps the lowest index on ties for both places.
  always_comb begin
    w_best_idx = r_best_idx;
    w_best_val = r_best_val;
    w_sec_idx  = r_sec_idx;
    w_sec_val  = r_sec_val;
    if (w_elem > r_best_val) begin
      w_sec_idx  = r_best_idx;
      w_sec_val  = r_best_val;
      w_best_idx = r_cnt;
      w_best_val = w_elem;
    end else if (!r_sec_valid || (w_elem > r_sec_val)) begin
      w_sec_idx = r_cnt;
      w_sec_val = w_elem;
    end
  end

  // Margin is formed one bit wider than the scores so it can never wrap.
  assign w_margin   = {w_best_val[DATA_W-1], w_best_val} - {w_sec_val[DATA_W-1], w_sec_val};
  assign w_low_conf = (32'(w_margin) < THRESHOLD);

  // Next-state logic for the IDLE -> SCAN -> DONE controller.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_SCAN;
      S_SCAN:  if (!enable) w_next = S_IDLE;
               else if (w_last) w_next = S_DONE;
      S_DONE:  if (!enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset wins over enable in every state.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Snapshot, running best/second tracking and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_sec_valid <= 1'b0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_sec_idx   <= '0;
      r_sec_val   <= '0;
      digit       <= '0;
      max_value   <= '0;
      runner_up   <= '0;
      margin      <= '0;
      low_conf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_snap      <= in_data;
            r_best_idx  <= '0;
            r_best_val  <= in_data[0];
            r_sec_valid <= 1'b0;
            r_cnt       <= IDX_W'(1);
          end
        end
        S_SCAN: begin
          if (enable) begin
            r_best_idx  <= w_best_idx;
            r_best_val  <= w_best_val;
            r_sec_idx   <= w_sec_idx;
            r_sec_val   <= w_sec_val;
            r_sec_valid <= 1'b1;
            r_cnt       <= r_cnt + IDX_W'(1);
            if (w_last) begin
              digit     <= w_best_idx;
              max_value <= w_best_val;
              runner_up <= w_sec_idx;
              margin    <= w_margin;
              low_conf  <= w_low_conf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == S_SCAN);
  assign layer_done = (r_state == S_DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_argmax_ranker.sv
// Directed bench for argmax_ranker: default 10x8 instance plus a 16x12
// instance for the wider configuration.
module tb_argmax_ranker;

  typedef logic signed [7:0]  vec10_t [0:9];
  typedef logic signed [11:0] vec16_t [0:15];

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance signals
  logic              en_a = 1'b0;
  vec10_t            in_a;
  logic [3:0]        digit_a, ru_a;
  logic signed [7:0] max_a;
  logic [8:0]        margin_a;
  logic              lc_a, busy_a, done_a;
  logic [1:0]        st_a;

  // Wide instance signals
  logic               en_b = 1'b0;
  vec16_t             in_b;
  logic [3:0]         digit_b, ru_b;
  logic signed [11:0] max_b;
  logic [12:0]        margin_b;
  logic               lc_b, busy_b, done_b;
  logic [1:0]         st_b;

  int n_tests = 0;
  int n_fail  = 0;

  argmax_ranker u_dut_a (
    .clk(clk), .reset(rst), .enable(en_a), .in_data(in_a),
    .digit(digit_a), .max_value(max_a), .runner_up(ru_a), .margin(margin_a),
    .low_conf(lc_a), .busy(busy_a), .layer_done(done_a), .dbg_state(st_a)
  );

  argmax_ranker #(.N_CLASSES(16), .DATA_W(12), .THRESHOLD(16)) u_dut_b (
    .clk(clk), .reset(rst), .enable(en_b), .in_data(in_b),
    .digit(digit_b), .max_value(max_b), .runner_up(ru_b), .margin(margin_b),
    .low_conf(lc_b), .busy(busy_b), .layer_done(done_b), .dbg_state(st_b)
  );

  // Driver: start a run from IDLE at a negedge, return edges after snapshot.
  task automatic do_run(input vec10_t v, output int edges);
    in_a = v;
    en_a = 1'b1;
    @(negedge clk);
    edges = 0;
    while (!done_a && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Driver: release enable so the DUT returns to IDLE.
  task automatic end_run();
    en_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) in_a[i] = '0;
    for (int i = 0; i < 16; i++) in_b[i] = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (digit_a !== 4'd0) begin n_fail++; $display("FAIL reset_digit: got %0d want 0", digit_a); end
    n_tests++; if (max_a !== 8'sd0) begin n_fail++; $display("FAIL reset_max: got %0d want 0", max_a); end
    n_tests++; if (ru_a !== 4'd0) begin n_fail++; $display("FAIL reset_runner_up: got %0d want 0", ru_a); end
    n_tests++; if (margin_a !== 9'd0) begin n_fail++; $display("FAIL reset_margin: got %0d want 0", margin_a); end
    n_tests++; if ({lc_a, busy_a, done_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {lc_a, busy_a, done_a}); end
    n_tests++; if ({busy_b, done_b} !== 2'b00) begin n_fail++; $display("FAIL reset_flags_wide: got %b want 00", {busy_b, done_b}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    vec10_t v;
    int edges;
    v = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    do_run(v, edges);
    n_tests++; if (edges !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", edges); end
    n_tests++; if (digit_a !== 4'd3) begin n_fail++; $display("FAIL basic_digit: got %0d want 3", digit_a); end
    n_tests++; if (max_a !== 8'sd85) begin n_fail++; $display("FAIL basic_max: got %0d want 85", max_a); end
    n_tests++; if (ru_a !== 4'd5) begin n_fail++; $display("FAIL basic_runner_up: got %0d want 5", ru_a); end
    n_tests++; if (margin_a !== 9'd75) begin n_fail++; $display("FAIL basic_margin: got %0d want 75", margin_a); end
    n_tests++; if ({lc_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL basic_lc_busy: got %b want 00", {lc_a, busy_a}); end
    // Result and layer_done hold while enable stays high.
    repeat (3) @(negedge clk);
    n_tests++; if ({done_a, busy_a, digit_a} !== {2'b10, 4'd3}) begin n_fail++; $display("FAIL basic_hold: got done=%b busy=%b digit=%0d want 1 0 3", done_a, busy_a, digit_a); end
    end_run();
    n_tests++; if ({done_a, busy_a, digit_a} !== {2'b00, 4'd3}) begin n_fail++; $display("FAIL basic_release: got done=%b busy=%b digit=%0d want 0 0 3", done_a, busy_a, digit_a); end
  endtask

  task automatic test_ties();
    vec10_t v;
    int edges;
    for (int i = 0; i < 10; i++) v[i] = 8'sd7;
    do_run(v, edges);
    n_tests++; if (edges !== 9) begin n_fail++; $display("FAIL ties_latency: got %0d want 9", edges); end
    n_tests++; if ({digit_a, ru_a} !== {4'd0, 4'd1}) begin n_fail++; $display("FAIL ties_idx: got digit=%0d ru=%0d want 0 1", digit_a, ru_a); end
    n_tests++; if (max_a !== 8'sd7) begin n_fail++; $display("FAIL ties_max: got %0d want 7", max_a); end
    n_tests++; if ({margin_a, lc_a} !== {9'd0, 1'b1}) begin n_fail++; $display("FAIL ties_margin: got margin=%0d lc=%b want 0 1", margin_a, lc_a); end
    end_run();
  endtask

  task automatic test_margin_edges();
    vec10_t v;
    int edges;
    // Widest possible spread: 127 vs -128 must give 255, not a wrapped value.
    for (int i = 0; i < 10; i++) v[i] = -8'sd128;
    v[0] = 8'sd127;
    do_run(v, edges);
    n_tests++; if ({digit_a, ru_a} !== {4'd0, 4'd1}) begin n_fail++; $display("FAIL wide_margin_idx: got digit=%0d ru=%0d want 0 1", digit_a, ru_a); end
    n_tests++; if ({margin_a, lc_a} !== {9'd255, 1'b0}) begin n_fail++; $display("FAIL wide_margin: got margin=%0d lc=%b want 255 0", margin_a, lc_a); end
    end_run();
    // Margin exactly at the threshold is confident.
    for (int i = 0; i < 10; i++) v[i] = 8'sd5;
    v[0] = 8'sd21;
    do_run(v, edges);
    n_tests++; if ({margin_a, lc_a} !== {9'd16, 1'b0}) begin n_fail++; $display("FAIL thresh_at: got margin=%0d lc=%b want 16 0", margin_a, lc_a); end
    end_run();
    // One below the threshold is low-confidence.
    v[0] = 8'sd20;
    do_run(v, edges);
    n_tests++; if ({margin_a, lc_a} !== {9'd15, 1'b1}) begin n_fail++; $display("FAIL thresh_below: got margin=%0d lc=%b want 15 1", margin_a, lc_a); end
    end_run();
  endtask

  task automatic test_negative();
    vec10_t v;
    int edges;
    for (int i = 0; i < 10; i++) v[i] = -8'sd128;
    v[9] = -8'sd1;
    do_run(v, edges);
    n_tests++; if (edges !== 9) begin n_fail++; $display("FAIL neg_latency: got %0d want 9", edges); end
    n_tests++; if ({digit_a, ru_a} !== {4'd9, 4'd0}) begin n_fail++; $display("FAIL neg_idx: got digit=%0d ru=%0d want 9 0", digit_a, ru_a); end
    n_tests++; if (max_a !== -8'sd1) begin n_fail++; $display("FAIL neg_max: got %0d want -1", max_a); end
    n_tests++; if ({margin_a, lc_a} !== {9'd127, 1'b0}) begin n_fail++; $display("FAIL neg_margin: got margin=%0d lc=%b want 127 0", margin_a, lc_a); end
    end_run();
  endtask

  // Previous result is the all -128 / -1 run: digit 9, max -1, margin 127.
  task automatic test_abort();
    vec10_t v;
    int edges;
    logic saw_done;
    v = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    saw_done = 1'b0;
    in_a = v;
    en_a = 1'b1;
    @(negedge clk);
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b want 1", busy_a); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
    end
    en_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b want 0", busy_a); end
    n_tests++; if ({digit_a, max_a, margin_a} !== {4'd9, 8'hFF, 9'd127}) begin n_fail++; $display("FAIL abort_hold: got digit=%0d max=%0d margin=%0d want 9 -1 127", digit_a, max_a, margin_a); end
    do_run(v, edges);
    n_tests++; if (edges !== 9) begin n_fail++; $display("FAIL rerun_latency: got %0d want 9", edges); end
    n_tests++; if ({digit_a, ru_a, margin_a} !== {4'd3, 4'd5, 9'd75}) begin n_fail++; $display("FAIL rerun_result: got digit=%0d ru=%0d margin=%0d want 3 5 75", digit_a, ru_a, margin_a); end
    end_run();
  endtask

  task automatic test_reset_midscan();
    vec10_t v1, v2, v3;
    int edges;
    v1 = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    v2 = '{10, -20, 30, -40, 50, -60, 70, -80, 90, -100};
    for (int i = 0; i < 10; i++) v3[i] = 8'sd100;
    in_a = v1;
    en_a = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({digit_a, ru_a, max_a, margin_a} !== 25'd0) begin n_fail++; $display("FAIL midreset_data: got digit=%0d ru=%0d max=%0d margin=%0d want 0", digit_a, ru_a, max_a, margin_a); end
    n_tests++; if ({lc_a, busy_a, done_a} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b want 000", {lc_a, busy_a, done_a}); end
    // Enable stays high through reset release: the run starts on the next edge.
    in_a = v2;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL postreset_start: got busy=%b want 1", busy_a); end
    in_a = v3;
    edges = 0;
    while (!done_a && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    n_tests++; if (edges !== 9) begin n_fail++; $display("FAIL snap_latency: got %0d want 9", edges); end
    n_tests++; if ({digit_a, ru_a} !== {4'd8, 4'd6}) begin n_fail++; $display("FAIL snap_idx: got digit=%0d ru=%0d want 8 6", digit_a, ru_a); end
    n_tests++; if ({max_a, margin_a, lc_a} !== {8'sd90, 9'd20, 1'b0}) begin n_fail++; $display("FAIL snap_value: got max=%0d margin=%0d lc=%b want 90 20 0", max_a, margin_a, lc_a); end
    end_run();
  endtask

  task automatic test_wide();
    int edges;
    for (int i = 0; i < 16; i++) in_b[i] = 12'(i);
    in_b[3] = 12'sd15;
    en_b = 1'b1;
    @(negedge clk);
    edges = 0;
    while (!done_b && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    n_tests++; if (edges !== 15) begin n_fail++; $display("FAIL wide_latency: got %0d want 15", edges); end
    n_tests++; if ({digit_b, ru_b} !== {4'd3, 4'd15}) begin n_fail++; $display("FAIL wide_idx: got digit=%0d ru=%0d want 3 15", digit_b, ru_b); end
    n_tests++; if (max_b !== 12'sd15) begin n_fail++; $display("FAIL wide_max: got %0d want 15", max_b); end
    n_tests++; if ({margin_b, lc_b, busy_b} !== {13'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wide_margin: got margin=%0d lc=%b busy=%b want 0 1 0", margin_b, lc_b, busy_b); end
    en_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_margin_edges();
    test_negative();
    test_abort();
    test_reset_midscan();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
